// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard FSM (branch flush, memory stall, load-use stall); HAZARD_PERF_CNT_EN adds perf counters
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] id_rs1,
  input  logic [3:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [3:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       branch_taken,
  input  logic       mem_busy,
  output logic [1:0] fd_flush,
  output logic [1:0] fd_nop,
  output logic       pc_hold,
  output logic       de_bubble,
  output logic       ex_hold,
  output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] perf_lu_stalls,
  output logic [15:0] perf_br_flushes,
  output logic [15:0] perf_mem_stalls
`endif
);
  typedef enum logic [1:0] {RUN, BR_FLUSH, MEM_WAIT} state_t;
  state_t state, state_nxt;
  logic lu, eval_run, go_br, go_mem, lu_stall, stall, flush;
  logic [7:0] cnt, cnt_nxt;
  logic to_q;
  assign lu = ex_mem_read && (ex_rd != 4'd0) &&
              ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  // state register, wait counter and sticky timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 8'd0;
      to_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      to_q  <= to_q | (cnt_nxt == 8'hff);
    end
  end
  // next state: a MEM_WAIT cycle with memory released is decided exactly as RUN
  always_comb begin
    eval_run  = (state == RUN) || (state == MEM_WAIT && !mem_busy);
    go_br     = eval_run && branch_taken;
    go_mem    = eval_run && !branch_taken && mem_busy;
    lu_stall  = eval_run && !branch_taken && !mem_busy && lu;
    stall     = go_mem || (state == MEM_WAIT && mem_busy);
    flush     = go_br || (state == BR_FLUSH);
    state_nxt = go_br ? BR_FLUSH : stall ? MEM_WAIT : RUN;
    cnt_nxt   = go_mem ? 8'd0 : (state == MEM_WAIT && mem_busy && cnt != 8'hff) ? cnt + 8'd1 : cnt;
  end
  // outputs: decode of state and inputs, forced to zero while reset is held
  always_comb begin
    fd_flush    = {1'b0, !reset && flush};
    fd_nop      = {1'b0, !reset && (stall || lu_stall)};
    pc_hold     = !reset && (stall || lu_stall);
    de_bubble   = !reset && (flush || lu_stall);
    ex_hold     = !reset && stall;
    mem_timeout = !reset && (to_q || cnt_nxt == 8'hff);
  end
`ifdef HAZARD_PERF_CNT_EN
  // saturating performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_lu_stalls  <= 16'd0;
      perf_br_flushes <= 16'd0;
      perf_mem_stalls <= 16'd0;
    end else begin
      if (lu_stall && perf_lu_stalls != 16'hffff) perf_lu_stalls <= perf_lu_stalls + 16'd1;
      if (go_br && perf_br_flushes != 16'hffff) perf_br_flushes <= perf_br_flushes + 16'd1;
      if (stall && perf_mem_stalls != 16'hffff) perf_mem_stalls <= perf_mem_stalls + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, branch_taken, mem_busy;
  logic [1:0] fd_flush, fd_nop;
  logic pc_hold, de_bubble, ex_hold, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] perf_lu_stalls, perf_br_flushes, perf_mem_stalls;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .fd_flush(fd_flush), .fd_nop(fd_nop), .pc_hold(pc_hold),
    .de_bubble(de_bubble), .ex_hold(ex_hold), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_lu_stalls(perf_lu_stalls), .perf_br_flushes(perf_br_flushes),
    .perf_mem_stalls(perf_mem_stalls)
`endif
  );
  task automatic idle();
    {id_rs1, id_rs2, ex_rd} = '0;
    {id_uses_rs1, id_uses_rs2, ex_mem_read, branch_taken, mem_busy} = '0;
  endtask
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  // expected vector order: fd_flush, fd_nop, pc_hold, de_bubble, ex_hold, mem_timeout
  task automatic chk(input string tag, input logic [1:0] ef, input logic [1:0] en,
                     input logic ep, input logic eb, input logic ee, input logic et);
    logic [7:0] obs, exp;
    #3;
    obs = {fd_flush, fd_nop, pc_hold, de_bubble, ex_hold, mem_timeout};
    exp = {ef, en, ep, eb, ee, et};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask
  task automatic set_lu(input logic [3:0] rd, input logic [3:0] r1, input logic u1,
                        input logic [3:0] r2, input logic u2);
    ex_mem_read = 1'b1; ex_rd = rd;
    id_rs1 = r1; id_uses_rs1 = u1; id_rs2 = r2; id_uses_rs2 = u2;
  endtask
  initial begin
    idle();
    reset = 1'b1;
    branch_taken = 1'b1; mem_busy = 1'b1;
    set_lu(4'd5, 4'd5, 1'b1, 4'd5, 1'b1);
    chk("reset_hold", 2'b00, 2'b00, 0, 0, 0, 0);
    next();
    next();
    chk("reset_hold2", 2'b00, 2'b00, 0, 0, 0, 0);
    idle();
    reset = 1'b0;
    next();
    chk("idle", 2'b00, 2'b00, 0, 0, 0, 0);
    set_lu(4'd5, 4'd0, 1'b0, 4'd5, 1'b1);
    chk("lu_rs2", 2'b00, 2'b01, 1, 1, 0, 0);
    next(); idle();
    chk("lu_gone", 2'b00, 2'b00, 0, 0, 0, 0);
    next(); set_lu(4'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    chk("lu_rd0", 2'b00, 2'b00, 0, 0, 0, 0);
    next(); set_lu(4'd3, 4'd3, 1'b1, 4'd9, 1'b0);
    chk("lu_rs1", 2'b00, 2'b01, 1, 1, 0, 0);
    next(); set_lu(4'd3, 4'd3, 1'b0, 4'd3, 1'b0);
    chk("lu_unused", 2'b00, 2'b00, 0, 0, 0, 0);
    next(); idle(); ex_rd = 4'd7; id_rs1 = 4'd7; id_uses_rs1 = 1'b1;
    chk("lu_not_load", 2'b00, 2'b00, 0, 0, 0, 0);
    next(); idle(); branch_taken = 1'b1;
    chk("br_c1", 2'b01, 2'b00, 0, 1, 0, 0);
    next(); branch_taken = 1'b0; mem_busy = 1'b1;
    chk("br_c2_ignore_busy", 2'b01, 2'b00, 0, 1, 0, 0);
    next(); idle();
    chk("br_done", 2'b00, 2'b00, 0, 0, 0, 0);
    next(); idle(); branch_taken = 1'b1;
    chk("br_again_c1", 2'b01, 2'b00, 0, 1, 0, 0);
    next(); idle(); branch_taken = 1'b1;
    chk("br_again_c2_ignore_br", 2'b01, 2'b00, 0, 1, 0, 0);
    next(); idle();
    chk("br_again_done", 2'b00, 2'b00, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      next(); idle(); mem_busy = 1'b1;
      chk($sformatf("mem_stall_%0d", i), 2'b00, 2'b01, 1, 0, 1, 0);
    end
    next(); idle(); branch_taken = 1'b1;
    chk("mem_release_br", 2'b01, 2'b00, 0, 1, 0, 0);
    next(); idle();
    chk("mem_release_br_c2", 2'b01, 2'b00, 0, 1, 0, 0);
    next(); idle();
    chk("after_br", 2'b00, 2'b00, 0, 0, 0, 0);
    next(); mem_busy = 1'b1; set_lu(4'd2, 4'd2, 1'b1, 4'd0, 1'b0);
    chk("busy_over_lu", 2'b00, 2'b01, 1, 0, 1, 0);
    next(); mem_busy = 1'b0;
    chk("release_lu", 2'b00, 2'b01, 1, 1, 0, 0);
    next(); idle();
    chk("release_lu_done", 2'b00, 2'b00, 0, 0, 0, 0);
    for (int i = 1; i <= 300; i++) begin
      next(); idle(); mem_busy = 1'b1;
      if (i == 255) chk("to_255", 2'b00, 2'b01, 1, 0, 1, 0);
      if (i == 256) chk("to_256", 2'b00, 2'b01, 1, 0, 1, 1);
      if (i == 300) chk("to_300", 2'b00, 2'b01, 1, 0, 1, 1);
    end
    next(); idle();
    chk("to_sticky", 2'b00, 2'b00, 0, 0, 0, 1);
    next(); reset = 1'b1;
    chk("to_reset", 2'b00, 2'b00, 0, 0, 0, 0);
    next(); reset = 1'b0;
    chk("to_cleared", 2'b00, 2'b00, 0, 0, 0, 0);
    next(); idle(); branch_taken = 1'b1;
    next(); idle();
    #1 reset = 1'b1;
    chk("rst_in_flush", 2'b00, 2'b00, 0, 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    assert (perf_br_flushes === 16'd0) else begin
      errors++;
      $error("FAIL perf_br_rst: got %0d want 0", perf_br_flushes);
    end
`endif
    next(); reset = 1'b0; set_lu(4'd4, 4'd4, 1'b1, 4'd0, 1'b0);
    chk("post_rst_run", 2'b00, 2'b01, 1, 1, 0, 0);
    next(); idle(); mem_busy = 1'b1;
    next(); mem_busy = 1'b1;
    #1 reset = 1'b1;
    chk("rst_in_stall", 2'b00, 2'b00, 0, 0, 0, 0);
    next(); reset = 1'b0; mem_busy = 1'b0;
    chk("post_rst_stall", 2'b00, 2'b00, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL: id_rs1, id_rs2  in  4 each  source register indices of the instruction in decode.
REQ-004 SHALL: id_uses_rs1, id_uses_rs2  in  1 each  source operand is actually read.
REQ-005 SHALL: ex_rd  in  4  destination register of the instruction in execute.
REQ-006 SHALL: ex_mem_read  in  1  instruction in execute is a load.
REQ-007 SHALL: branch_taken  in  1  execute resolved a taken branch/jump this cycle.
REQ-008 SHALL: mem_busy  in  1  data memory cannot complete this cycle.
REQ-009 SHALL: fd_flush  out  2  to fetch/decode register: 00 = normal, 01 = load zero instruction.
REQ-010 SHALL: fd_nop  out  2  to fetch/decode register: 00 = advance, 01 = hold contents.
REQ-011 SHALL: pc_hold  out  1  PC keeps its current value.
REQ-012 SHALL: de_bubble  out  1  decode/execute register loads an all-zero instruction.
REQ-013 SHALL: ex_hold  out  1  execute and later stages freeze.
REQ-014 SHALL: mem_timeout  out  1  sticky flag, memory stall exceeded its limit.

Function
REQ-015 SHALL: FSM states RUN, BR_FLUSH, MEM_WAIT; outputs are a combinational decode of state and current inputs; state is registered.
REQ-016 SHALL: load-use hazard = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
REQ-017 SHALL: priority in RUN is branch_taken > mem_busy > load-use hazard > normal.
REQ-018 SHALL: in RUN with branch_taken: fd_flush=01, de_bubble=1, pc_hold=0, fd_nop=00; next state BR_FLUSH.
REQ-019 SHALL: in BR_FLUSH: fd_flush=01, de_bubble=1 for exactly one cycle, with branch_taken and mem_busy ignored; next state RUN. Total branch penalty is 2 cycles.
REQ-020 SHALL: in RUN with mem_busy and no branch_taken: fd_nop=01, pc_hold=1, ex_hold=1; next state MEM_WAIT.
REQ-021 SHALL: in MEM_WAIT: fd_nop=01, pc_hold=1, ex_hold=1 while mem_busy=1. On the cycle mem_busy=0, the state returns to RUN and that cycle's outputs are evaluated as in RUN (branch_taken has priority).
REQ-022 SHALL: load-use hazard in RUN: fd_nop=01, pc_hold=1, de_bubble=1 for that cycle only; the state remains RUN.
REQ-023 SHALL: normal operation: all outputs 0.
REQ-024 SHALL: an 8-bit wait counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle, saturating at 255.
REQ-025 SHALL: when the wait counter reaches 255, mem_timeout sets and stays 1 until reset; the stall continues.
REQ-026 SHALL: fd_flush[1] and fd_nop[1] are always 0; fd_flush and fd_nop are never both nonzero.

Reset
REQ-027 SHALL: while reset=1, the state is RUN and all outputs are 0, regardless of other inputs.
REQ-028 SHALL: reset asserted mid-stall or mid-flush aborts it immediately; the first cycle after deassertion evaluates as RUN.
REQ-029 SHALL: reset clears the wait counter, mem_timeout, and all performance counters.

Configuration
REQ-030 SHALL: macro HAZARD_PERF_CNT_EN, when defined, adds outputs perf_lu_stalls, perf_br_flushes and perf_mem_stalls, each 16 bits and saturating.
REQ-031 SHALL: with HAZARD_PERF_CNT_EN, the counters count, respectively, load-use stall cycles, BR_FLUSH entries, and cycles with ex_hold=1.
REQ-032 SHALL: without HAZARD_PERF_CNT_EN, those ports and their logic are absent; all other behaviour is identical.

Verification
REQ-033 SHALL: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for 1 cycle -> fd_nop=01, pc_hold=1, de_bubble=1 that cycle; next cycle with hazard gone -> all outputs 0.
REQ-034 SHALL: same as REQ-033 but ex_rd=0 -> no stall.
REQ-035 SHALL: branch_taken=1 for 1 cycle -> fd_flush=01, de_bubble=1 for 2 consecutive cycles, pc_hold=0 throughout.
REQ-036 SHALL: mem_busy=1 for 3 cycles -> ex_hold=1 for those 3 cycles; branch_taken=1 on the release cycle -> flush begins on that cycle.
REQ-037 SHALL: mem_busy held for 300 cycles -> mem_timeout=1 from the 256th stall cycle; reset pulse -> mem_timeout=0 and all outputs 0.
REQ-038 SHALL: reset asserted during BR_FLUSH -> outputs drop to 0 asynchronously; with HAZARD_PERF_CNT_EN, perf_br_flushes=0.
